// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: the machine word and the memory responder's state and owner encodings.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic {
      IDLE,
      BUSY
   } memresp_state_t;

   typedef enum logic {
      OWNER_I,
      OWNER_D
   } mem_owner_t;

endpackage

// File: rtl/memory_responder_if.sv
// Cache/RAM side bundle of the memory responder: icache and dcache handshakes plus the RAM port.
interface memory_responder_if;

   logic                 iREN;
   cpu_types_pkg::word_t iaddr;
   logic                 iwait;
   cpu_types_pkg::word_t iload;

   logic                 dREN;
   logic                 dWEN;
   cpu_types_pkg::word_t daddr;
   cpu_types_pkg::word_t dstore;
   logic                 dwait;
   cpu_types_pkg::word_t dload;

   logic                 ram_ren;
   logic                 ram_wen;
   cpu_types_pkg::word_t ram_addr;
   cpu_types_pkg::word_t ram_wdata;
   cpu_types_pkg::word_t ram_rdata;

   // master = the caches together with the RAM; slave = the responder sitting between them
   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_rdata,
      input  iwait, iload, dwait, dload, ram_ren, ram_wen, ram_addr, ram_wdata
   );

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_rdata,
      output iwait, iload, dwait, dload, ram_ren, ram_wen, ram_addr, ram_wdata
   );

endinterface

// File: rtl/mem_grant_arb.sv
// Priority and starvation decision: dcache first unless the icache has watched MAXD dcache grants in a row.
module mem_grant_arb
   import cpu_types_pkg::*;
#(
   parameter int MAXD = 4,
   localparam int STRK_W = $clog2(MAXD + 1)
) (
   input  logic              i_req,
   input  logic              d_req,
   input  logic [STRK_W-1:0] dstreak,
   output logic              grant_valid,
   output mem_owner_t        grant_owner,
   output logic [STRK_W-1:0] dstreak_next
);

   // The streak only grows while the icache is actually being passed over
   always_comb begin
      grant_valid  = 1'b0;
      grant_owner  = OWNER_D;
      dstreak_next = dstreak;
      if (d_req && (!i_req || (dstreak < STRK_W'(MAXD)))) begin
         grant_valid  = 1'b1;
         grant_owner  = OWNER_D;
         dstreak_next = i_req ? (dstreak + STRK_W'(1)) : '0;
      end else if (i_req) begin
         grant_valid  = 1'b1;
         grant_owner  = OWNER_I;
         dstreak_next = '0;
      end
   end

endmodule

// File: rtl/memory_responder.sv
// Arbitrates icache fetches and dcache loads/stores onto one fixed-latency RAM port
// and returns a one-cycle wait-low completion pulse to whichever cache owned the access.
module memory_responder
   import cpu_types_pkg::*;
#(
   parameter int LAT  = 2,
   parameter int MAXD = 4
) (
   input logic              CLK,
   input logic              RST,
   memory_responder_if.slave bus
);

   localparam int CNT_W  = $clog2(LAT + 1);
   localparam int STRK_W = $clog2(MAXD + 1);

   memresp_state_t    state_q, state_d;
   mem_owner_t        owner_q, owner_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [STRK_W-1:0] dstreak_q, dstreak_d;

   logic              grant_valid;
   mem_owner_t        grant_owner;
   logic [STRK_W-1:0] grant_dstreak;
   logic              done;

   mem_grant_arb #(.MAXD(MAXD)) u_arb (
      .i_req        (bus.iREN),
      .d_req        (bus.dREN | bus.dWEN),
      .dstreak      (dstreak_q),
      .grant_valid  (grant_valid),
      .grant_owner  (grant_owner),
      .dstreak_next (grant_dstreak)
   );

   assign done = (state_q == BUSY) && (cnt_q == '0);

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      dstreak_d = dstreak_q;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               state_d   = BUSY;
               owner_d   = grant_owner;
               cnt_d     = CNT_W'(LAT - 1);
               dstreak_d = grant_dstreak;
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         owner_q   <= OWNER_D;
         cnt_q     <= '0;
         dstreak_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         cnt_q     <= cnt_d;
         dstreak_q <= dstreak_d;
      end
   end

   // Strobes follow the owner's live request so a dropped request simply stops strobing
   always_comb begin
      bus.ram_ren   = 1'b0;
      bus.ram_wen   = 1'b0;
      bus.ram_addr  = '0;
      bus.ram_wdata = '0;
      if (state_q == BUSY) begin
         if (owner_q == OWNER_D) begin
            if (bus.dWEN) begin
               bus.ram_wen   = 1'b1;
               bus.ram_addr  = bus.daddr;
               bus.ram_wdata = bus.dstore;
            end else if (bus.dREN) begin
               bus.ram_ren  = 1'b1;
               bus.ram_addr = bus.daddr;
            end
         end else begin
            bus.ram_ren  = bus.iREN;
            bus.ram_addr = bus.iaddr;
         end
      end
   end

   always_comb begin
      bus.iwait = 1'b1;
      bus.dwait = 1'b1;
      bus.iload = '0;
      bus.dload = '0;
      if (done) begin
         if (owner_q == OWNER_I) begin
            bus.iwait = 1'b0;
            bus.iload = bus.ram_rdata;
         end else begin
            bus.dwait = 1'b0;
            bus.dload = bus.dWEN ? '0 : bus.ram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: LAT=2/MAXD=4 instance for the directed and random
// scenarios, plus a LAT=1 instance for the fast alternating sweep.
module tb_memory_responder;
   import cpu_types_pkg::*;

   localparam int LAT  = 2;
   localparam int MAXD = 4;

   logic CLK = 1'b0;
   logic RST;
   int   checks = 0;
   int   errors = 0;

   always #5 CLK = ~CLK;

   memory_responder_if bus ();
   memory_responder_if bus1 ();

   memory_responder #(.LAT(LAT), .MAXD(MAXD)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   memory_responder #(.LAT(1), .MAXD(MAXD)) dut1 (
      .CLK (CLK),
      .RST (RST),
      .bus (bus1.slave)
   );

   // Initial RAM image: one recognisable word at 0x40, a pattern everywhere else
   function automatic word_t seed(input logic [7:0] a);
      return (a == 8'h40) ? 32'hDEADBEEF : {16'hC0DE, 8'h5A, a};
   endfunction

   word_t ram0_val [256];
   bit    ram0_wr  [256];
   word_t ram1_val [256];
   bit    ram1_wr  [256];

   always_comb begin
      bus.ram_rdata = '0;
      if (bus.ram_ren)
         bus.ram_rdata = ram0_wr[bus.ram_addr[7:0]] ? ram0_val[bus.ram_addr[7:0]] : seed(bus.ram_addr[7:0]);
   end

   always_comb begin
      bus1.ram_rdata = '0;
      if (bus1.ram_ren)
         bus1.ram_rdata = ram1_wr[bus1.ram_addr[7:0]] ? ram1_val[bus1.ram_addr[7:0]] : seed(bus1.ram_addr[7:0]);
   end

   always @(posedge CLK) begin
      if (bus.ram_wen) begin
         ram0_val[bus.ram_addr[7:0]] <= bus.ram_wdata;
         ram0_wr[bus.ram_addr[7:0]]  <= 1'b1;
      end
      if (bus1.ram_wen) begin
         ram1_val[bus1.ram_addr[7:0]] <= bus1.ram_wdata;
         ram1_wr[bus1.ram_addr[7:0]]  <= 1'b1;
      end
   end

   // Expected memory contents, updated only when a write completes
   word_t exp_val [2][256];
   bit    exp_wr  [2][256];

   function automatic word_t exp_read(input int u, input logic [7:0] a);
      return exp_wr[u][a] ? exp_val[u][a] : seed(a);
   endfunction

   task automatic exp_write(input int u, input logic [7:0] a, input word_t v);
      exp_val[u][a] = v;
      exp_wr[u][a]  = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      bus.iREN   = 0; bus.iaddr  = '0; bus.dREN  = 0; bus.dWEN  = 0;
      bus.daddr  = '0; bus.dstore = '0;
      bus1.iREN  = 0; bus1.iaddr = '0; bus1.dREN = 0; bus1.dWEN = 0;
      bus1.daddr = '0; bus1.dstore = '0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      clear_inputs();
      @(posedge CLK);
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge CLK);
      checks++; if (bus.iwait !== 1'b1) begin errors++; $display("[TB] FAIL reset_iwait: got %b expected 1", bus.iwait); end
      checks++; if (bus.dwait !== 1'b1) begin errors++; $display("[TB] FAIL reset_dwait: got %b expected 1", bus.dwait); end
      checks++; if (bus.iload !== 32'h0) begin errors++; $display("[TB] FAIL reset_iload: got %h expected 0", bus.iload); end
      checks++; if (bus.dload !== 32'h0) begin errors++; $display("[TB] FAIL reset_dload: got %h expected 0", bus.dload); end
      checks++; if ({bus.ram_ren, bus.ram_wen} !== 2'b00) begin errors++; $display("[TB] FAIL reset_strobes: got %b expected 00", {bus.ram_ren, bus.ram_wen}); end
      checks++; if (bus.ram_addr !== 32'h0 || bus.ram_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_ram_bus: got %h/%h expected 0/0", bus.ram_addr, bus.ram_wdata); end
      checks++; if ({bus1.iwait, bus1.dwait, bus1.ram_ren, bus1.ram_wen} !== 4'b1100) begin errors++; $display("[TB] FAIL reset_lat1: got %b expected 1100", {bus1.iwait, bus1.dwait, bus1.ram_ren, bus1.ram_wen}); end
      next_cycle();
   endtask

   task automatic test_single_read();
      do_reset();
      bus.dREN  = 1'b1;
      bus.daddr = 32'h40;
      for (int c = 0; c <= LAT; c++) begin
         @(negedge CLK);
         checks++; if (bus.ram_ren !== (c >= 1)) begin errors++; $display("[TB] FAIL read_ram_ren c%0d: got %b expected %b", c, bus.ram_ren, (c >= 1)); end
         checks++; if (bus.dwait !== (c != LAT)) begin errors++; $display("[TB] FAIL read_dwait c%0d: got %b expected %b", c, bus.dwait, (c != LAT)); end
         checks++; if (bus.iwait !== 1'b1) begin errors++; $display("[TB] FAIL read_iwait c%0d: got %b expected 1", c, bus.iwait); end
         if (c >= 1) begin
            checks++; if (bus.ram_addr !== 32'h40) begin errors++; $display("[TB] FAIL read_ram_addr c%0d: got %h expected 40", c, bus.ram_addr); end
         end
         if (c == LAT) begin
            checks++; if (bus.dload !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_dload: got %h expected deadbeef", bus.dload); end
         end
         next_cycle();
      end
      bus.dREN = 1'b0;
   endtask

   task automatic test_write();
      do_reset();
      bus.dREN   = 1'b1;
      bus.dWEN   = 1'b1;
      bus.daddr  = 32'h3100;
      bus.dstore = 32'h1234;
      for (int c = 0; c <= LAT; c++) begin
         @(negedge CLK);
         checks++; if (bus.ram_wen !== (c >= 1) || bus.ram_ren !== 1'b0) begin errors++; $display("[TB] FAIL write_strobes c%0d: got wen=%b ren=%b expected wen=%b ren=0", c, bus.ram_wen, bus.ram_ren, (c >= 1)); end
         checks++; if (bus.dwait !== (c != LAT)) begin errors++; $display("[TB] FAIL write_dwait c%0d: got %b expected %b", c, bus.dwait, (c != LAT)); end
         if (c >= 1) begin
            checks++; if (bus.ram_wdata !== 32'h1234 || bus.ram_addr !== 32'h3100) begin errors++; $display("[TB] FAIL write_ram_bus c%0d: got %h@%h expected 1234@3100", c, bus.ram_wdata, bus.ram_addr); end
         end
         if (c == LAT) begin
            checks++; if (bus.dload !== 32'h0) begin errors++; $display("[TB] FAIL write_dload: got %h expected 0", bus.dload); end
            exp_write(0, 8'h00, 32'h1234);
         end
         next_cycle();
      end
      bus.dREN = 1'b0;
      bus.dWEN = 1'b0;
   endtask

   task automatic test_simultaneous();
      int last;
      last = 2 * LAT + 1;
      do_reset();
      bus.iREN  = 1'b1;
      bus.iaddr = 32'h10;
      bus.dREN  = 1'b1;
      bus.daddr = 32'h20;
      for (int c = 0; c <= last; c++) begin
         @(negedge CLK);
         checks++; if (bus.dwait !== (c != LAT)) begin errors++; $display("[TB] FAIL simul_dwait c%0d: got %b expected %b", c, bus.dwait, (c != LAT)); end
         checks++; if (bus.iwait !== (c != last)) begin errors++; $display("[TB] FAIL simul_iwait c%0d: got %b expected %b", c, bus.iwait, (c != last)); end
         if (c == LAT) begin
            checks++; if (bus.dload !== exp_read(0, 8'h20)) begin errors++; $display("[TB] FAIL simul_dload: got %h expected %h", bus.dload, exp_read(0, 8'h20)); end
         end
         if (c == last) begin
            checks++; if (bus.iload !== exp_read(0, 8'h10)) begin errors++; $display("[TB] FAIL simul_iload: got %h expected %h", bus.iload, exp_read(0, 8'h10)); end
         end
         next_cycle();
         if (c == LAT)  bus.dREN = 1'b0;
         if (c == last) bus.iREN = 1'b0;
      end
   endtask

   task automatic test_starvation();
      bit is_d [6];
      int when [6];
      int n;
      n = 0;
      do_reset();
      bus.iREN  = 1'b1;
      bus.iaddr = 32'h84;
      bus.dREN  = 1'b1;
      bus.daddr = 32'h88;
      for (int c = 0; c < 60 && n < 6; c++) begin
         @(negedge CLK);
         if (!bus.dwait && n < 6) begin is_d[n] = 1'b1; when[n] = c; n++; end
         if (!bus.iwait && n < 6) begin is_d[n] = 1'b0; when[n] = c; n++; end
         next_cycle();
      end
      checks++; if (n != 6) begin errors++; $display("[TB] FAIL starve_count: got %0d completions expected 6", n); end
      for (int k = 0; k < n; k++) begin
         checks++; if (is_d[k] !== (k != MAXD)) begin errors++; $display("[TB] FAIL starve_owner%0d: got dcache=%b expected dcache=%b", k, is_d[k], (k != MAXD)); end
         checks++; if (when[k] != LAT + k * (LAT + 1)) begin errors++; $display("[TB] FAIL starve_time%0d: got %0d expected %0d", k, when[k], LAT + k * (LAT + 1)); end
      end
      clear_inputs();
   endtask

   task automatic test_reset_abort();
      do_reset();
      bus.iREN  = 1'b1;
      bus.iaddr = 32'h44;
      @(negedge CLK);
      checks++; if (bus.ram_ren !== 1'b0 || bus.iwait !== 1'b1) begin errors++; $display("[TB] FAIL abort_c0: got ren=%b iwait=%b expected ren=0 iwait=1", bus.ram_ren, bus.iwait); end
      next_cycle();
      @(negedge CLK);
      checks++; if (bus.ram_ren !== 1'b1) begin errors++; $display("[TB] FAIL abort_c1_ren: got %b expected 1", bus.ram_ren); end
      RST = 1'b1;
      next_cycle();
      RST = 1'b0;
      bus.iREN = 1'b0;
      @(negedge CLK);
      checks++; if (bus.ram_ren !== 1'b0 || bus.iwait !== 1'b1) begin errors++; $display("[TB] FAIL abort_c2: got ren=%b iwait=%b expected ren=0 iwait=1", bus.ram_ren, bus.iwait); end
      for (int c = 0; c < 6; c++) begin
         next_cycle();
         @(negedge CLK);
         checks++; if (bus.iwait !== 1'b1 || bus.ram_ren !== 1'b0) begin errors++; $display("[TB] FAIL abort_quiet c%0d: got iwait=%b ren=%b expected 1/0", c + 3, bus.iwait, bus.ram_ren); end
      end
      next_cycle();
   endtask

   // Random rounds: each round issues a dcache and/or icache request from IDLE and
   // predicts completion cycles and data from the arbitration rules and the memory model.
   task automatic test_random_mixed();
      int    streak;
      bit    d, i, dwr, d_first;
      word_t da, ia, dsd;
      int    d_done, i_done, last, d_start, i_start;
      bit    exp_ren, exp_wen;
      streak = 0;
      do_reset();
      for (int r = 0; r < 40; r++) begin
         int sel;
         sel = int'($urandom_range(1, 3));
         d   = sel[0];
         i   = sel[1];
         dwr = 1'($urandom_range(0, 1));
         da  = $urandom;
         ia  = $urandom;
         dsd = $urandom;
         d_first = d && (!i || streak < MAXD);
         d_done = -1;
         i_done = -1;
         if (d_first) begin
            d_done = LAT;
            if (i) i_done = 2 * LAT + 1;
            streak = i ? streak + 1 : 0;
            if (i) streak = 0;
         end else begin
            i_done = LAT;
            if (d) d_done = 2 * LAT + 1;
            streak = 0;
         end
         last    = (d_done > i_done) ? d_done : i_done;
         d_start = d_done - LAT + 1;
         i_start = i_done - LAT + 1;
         bus.dREN   = d;
         bus.dWEN   = d && dwr;
         bus.daddr  = da;
         bus.dstore = dsd;
         bus.iREN   = i;
         bus.iaddr  = ia;
         for (int c = 0; c <= last; c++) begin
            @(negedge CLK);
            exp_wen = d && dwr && c >= d_start && c <= d_done;
            exp_ren = (d && !dwr && c >= d_start && c <= d_done) || (i && c >= i_start && c <= i_done);
            checks++; if (bus.ram_ren !== exp_ren || bus.ram_wen !== exp_wen) begin errors++; $display("[TB] FAIL rand%0d_strobes c%0d: got ren=%b wen=%b expected ren=%b wen=%b", r, c, bus.ram_ren, bus.ram_wen, exp_ren, exp_wen); end
            checks++; if (bus.dwait !== !(c == d_done) || bus.iwait !== !(c == i_done)) begin errors++; $display("[TB] FAIL rand%0d_waits c%0d: got dwait=%b iwait=%b expected %b/%b", r, c, bus.dwait, bus.iwait, !(c == d_done), !(c == i_done)); end
            if (c == d_done) begin
               checks++; if (bus.dload !== (dwr ? 32'h0 : exp_read(0, da[7:0]))) begin errors++; $display("[TB] FAIL rand%0d_dload: got %h expected %h", r, bus.dload, (dwr ? 32'h0 : exp_read(0, da[7:0]))); end
               if (dwr) exp_write(0, da[7:0], dsd);
            end
            if (c == i_done) begin
               checks++; if (bus.iload !== exp_read(0, ia[7:0])) begin errors++; $display("[TB] FAIL rand%0d_iload: got %h expected %h", r, bus.iload, exp_read(0, ia[7:0])); end
            end
            next_cycle();
            if (c == d_done) begin bus.dREN = 1'b0; bus.dWEN = 1'b0; end
            if (c == i_done) bus.iREN = 1'b0;
         end
      end
   endtask

   task automatic test_lat1_sweep();
      word_t a, v;
      bit    wr;
      do_reset();
      for (int t = 0; t < 20; t++) begin
         a  = $urandom;
         v  = $urandom;
         wr = 1'($urandom_range(0, 1));
         if (t % 2 == 0) begin
            bus1.iREN  = 1'b1;
            bus1.iaddr = a;
         end else begin
            bus1.dREN   = 1'b1;
            bus1.dWEN   = wr;
            bus1.daddr  = a;
            bus1.dstore = v;
         end
         @(negedge CLK);
         checks++; if (bus1.iwait !== 1'b1 || bus1.dwait !== 1'b1 || bus1.ram_ren !== 1'b0 || bus1.ram_wen !== 1'b0) begin errors++; $display("[TB] FAIL lat1_grant%0d: got iw=%b dw=%b ren=%b wen=%b expected 1 1 0 0", t, bus1.iwait, bus1.dwait, bus1.ram_ren, bus1.ram_wen); end
         next_cycle();
         @(negedge CLK);
         if (t % 2 == 0) begin
            checks++; if (bus1.iwait !== 1'b0 || bus1.dwait !== 1'b1 || bus1.ram_ren !== 1'b1) begin errors++; $display("[TB] FAIL lat1_idone%0d: got iw=%b dw=%b ren=%b expected 0 1 1", t, bus1.iwait, bus1.dwait, bus1.ram_ren); end
            checks++; if (bus1.iload !== exp_read(1, a[7:0])) begin errors++; $display("[TB] FAIL lat1_iload%0d: got %h expected %h", t, bus1.iload, exp_read(1, a[7:0])); end
         end else begin
            checks++; if (bus1.dwait !== 1'b0 || bus1.iwait !== 1'b1 || bus1.ram_wen !== wr || bus1.ram_ren !== !wr) begin errors++; $display("[TB] FAIL lat1_ddone%0d: got dw=%b iw=%b wen=%b ren=%b expected 0 1 %b %b", t, bus1.dwait, bus1.iwait, bus1.ram_wen, bus1.ram_ren, wr, !wr); end
            checks++; if (bus1.dload !== (wr ? 32'h0 : exp_read(1, a[7:0]))) begin errors++; $display("[TB] FAIL lat1_dload%0d: got %h expected %h", t, bus1.dload, (wr ? 32'h0 : exp_read(1, a[7:0]))); end
            if (wr) exp_write(1, a[7:0], v);
         end
         next_cycle();
         bus1.iREN = 1'b0;
         bus1.dREN = 1'b0;
         bus1.dWEN = 1'b0;
      end
   endtask

   initial begin
      RST = 1'b1;
      clear_inputs();
      test_reset();
      test_single_read();
      test_write();
      test_simultaneous();
      test_starvation();
      test_reset_abort();
      test_random_mixed();
      test_lat1_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/memory_responder.md
# memory_responder

Responder end of the cache-to-memory protocol. Accepts instruction-fetch requests from the icache and load/store requests from the dcache, arbitrates them onto one single-ported RAM with fixed access latency, and returns per-requester `wait`/`load` handshakes: `wait` stays high while a request is outstanding and drops for exactly one cycle with read data valid. It sits between both caches and main memory.

## Interface
Parameters:
- `LAT`, 2: RAM access latency in cycles, ≥1.
- `MAXD`, 4: consecutive dcache grants allowed while icache is waiting before icache is forced a grant, ≥1.

Ports:
- `CLK`  in  1  clock, all state on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `iREN`  in  1  icache read request.
- `iaddr`  in  32  icache word address.
- `iwait`  out  1  icache wait, low for one cycle on completion.
- `iload`  out  32  icache read data, valid when `iwait`=0.
- `dREN`  in  1  dcache read request.
- `dWEN`  in  1  dcache write request.
- `daddr`  in  32  dcache word address.
- `dstore`  in  32  dcache write data.
- `dwait`  out  1  dcache wait, low for one cycle on completion.
- `dload`  out  32  dcache read data, valid when `dwait`=0.
- `ram_ren`  out  1  RAM read strobe.
- `ram_wen`  out  1  RAM write strobe.
- `ram_addr`  out  32  RAM address.
- `ram_wdata`  out  32  RAM write data.
- `ram_rdata`  in  32  RAM read data, valid in the LAT-th strobe cycle.

## Operation
- States: IDLE, BUSY. Registers: `owner` (I/D), `cnt` ($clog2(LAT+1) bits), `dstreak` ($clog2(MAXD+1) bits).
- IDLE arbitration:
  - If dcache requests and (`iREN`=0 or `dstreak`<MAXD): `owner`=D, and `dstreak` increments if `iREN`=1, otherwise clears to 0.
  - Else if `iREN`: `owner`=I, `dstreak` cleared.
  - A grant loads `cnt`=LAT-1 and moves to BUSY. With no request the block stays in IDLE.
- BUSY drives `ram_*` combinationally from the owner's live inputs:
  - D owner, `dWEN`=1: write. `dWEN` wins over `dREN` when both are set.
  - D owner, read only: read.
  - I owner: always read.
- BUSY counting:
  - `cnt`≠0: decrement each cycle.
  - `cnt`=0: completion cycle. The owner's `wait` is 0 and its `load` = `ram_rdata` (0 for writes). Next state is IDLE.
- `iwait`/`dwait` are 1 in every cycle except their own completion cycle. `iload`/`dload` are 0 outside completion.
- A requester dropping its request mid-BUSY does not abort the access: the strobes follow the live request and the wait pulse is still produced. Requesters must hold requests stable while `wait`=1.
- The address is forwarded unmodified; bits [1:0] are not interpreted.

## Timing
- Reset values: state IDLE, `cnt`=0, `dstreak`=0, `owner`=D, `iwait`=`dwait`=1, `iload`=`dload`=0, all `ram_*`=0.
- A request first seen in IDLE at cycle 0 produces strobes in cycles 1..LAT and wait=0 in cycle LAT.
- Back-to-back requests have one IDLE bubble, so the period is LAT+1 cycles.
- An icache request arriving while the dcache is in BUSY waits. It is granted in the next IDLE if the dcache is not requesting or `dstreak`=MAXD.
- `RST` asserted mid-BUSY:
  - At the next edge the block returns to IDLE with reset values and strobes drop.
  - No wait pulse is issued for the aborted access.
- No combinational path from `ram_rdata` to strobes. Paths from the request inputs to `ram_*` are combinational in BUSY only.

## Structure
- `word_t` and the new `memresp_state_t` (IDLE, BUSY) and `mem_owner_t` (I, D) enums go in `cpu_types_pkg`.
- The priority and starvation decision (inputs: request bits and `dstreak`; outputs: grant and next `dstreak`) is one combinational sub-module, `mem_grant_arb`.
- The FSM, latency counter, and output muxing stay in `memory_responder`.

## Test plan
- Single dcache read, LAT=2: `dREN`=1, `daddr`=0x40, `ram_rdata`=0xDEADBEEF in the completion cycle -> `ram_ren`=1 in cycles 1–2, `dwait`=0 only in cycle 2, `dload`=0xDEADBEEF, `iwait` stays 1.
- Dcache write with `dREN`=`dWEN`=1, `dstore`=0x1234 at 0x3100 -> `ram_wen`=1, `ram_ren`=0, `ram_wdata`=0x1234, `dwait` pulse in cycle 2, `dload`=0.
- Simultaneous `iREN`+`dREN` from IDLE -> dcache served first. Icache is granted in the following IDLE and `iwait`=0 at cycle 5.
- Starvation, MAXD=4: `iREN` and `dREN` held continuously -> 4 dcache completions, then 1 icache completion, then the dcache resumes.
- Reset at cycle 1 of an icache read -> cycle 2 shows IDLE, `ram_ren`=0, `iwait`=1, and no pulse is ever produced for that access.
- LAT=1 sweep with alternating i/d requests -> every completion occurs 1 cycle after the grant with a period of 2 cycles, and data matches the RAM model at each address.
